wbm_spi_cmd: RTL and testbench
==============================

// Module: wbm_spi_cmd
//
// PURPOSE
// Wishbone-domain consumer of the byte stream received by the SPI slave
// receiver. Imports each byte over the two-phase req/ack handshake,
// decodes a 1- or 2-byte command, and runs one Wishbone B4 classic master
// cycle per command. Read results go to the SPI transmit path over a
// valid/ready byte interface.
//
// PARAMETERS
// ADDR_WIDTH      7    Wishbone address width, 1..7; command bits [6:0] truncated to it
// TIMEOUT_CYCLES  255  clk cycles without wb_ack_i before abort (WBM_SPI_TIMEOUT_EN only)
//
// PORTS
// clk             in   1   Wishbone clock
// rst             in   1   asynchronous, active-high reset
// handshake_req   in   1   toggles once per new byte from SPI domain (async)
// handshake_data  in   8   byte; stable from req toggle until ack matches req
// handshake_ack   out  1   set equal to synchronised req once byte is taken
// wb_cyc_o        out  1   Wishbone cycle
// wb_stb_o        out  1   Wishbone strobe
// wb_we_o         out  1   1 = write cycle
// wb_adr_o        out  ADDR_WIDTH  Wishbone address
// wb_dat_o        out  8   write data
// wb_dat_i        in   8   read data
// wb_ack_i        in   1   Wishbone acknowledge
// tx_stb          out  1   read result valid
// tx_data         out  8   read result
// tx_ready        in   1   transmit path accepts tx_data when tx_stb && tx_ready
//
// BEHAVIOUR
// - Reset: all outputs 0; req synchroniser (2 FF) 0; state IDLE.
// - Byte pending when synchronised req != handshake_ack. Take = latch
//   handshake_data, handshake_ack <= synchronised req (same edge). Take only
//   in IDLE or DATA; elsewhere byte stays pending (backpressure into SPI side).
// - Latency: req toggle -> ack toggle in 3 clk (2 sync + 1 take).
// - Command byte: bit7 = WE, bits[6:0] = address. No framing: stream is
//   strictly cmd[,data],cmd...; desync only recovered by rst.
// - FSM:
//   IDLE: take byte; WE=1 -> latch adr, DATA; WE=0 -> latch adr, WB (read).
//   DATA: take byte into wb_dat_o -> WB (write).
//   WB:   cyc=stb=1, we per cmd, until wb_ack_i sampled high; on ack deassert
//         cyc/stb same edge; read: tx_data <= wb_dat_i, tx_stb <= 1 -> TX;
//         write -> IDLE. Min cycle: 1 clk with cyc (ack in first cycle).
//   TX:   hold tx_stb/tx_data until tx_ready high at a clk edge; then tx_stb<=0,
//         IDLE. tx_data unchanged while tx_stb=1.
// - wb_adr_o, wb_we_o, wb_dat_o held constant through the whole cycle.
// - No pipelining: at most one Wishbone cycle in flight, one tx byte pending.
// - Reset mid-cycle: cyc/stb/tx_stb drop asynchronously; pending byte
//   retaken after reset only if SPI side still holds req != 0.
//
// CONFIGURATION
// WBM_SPI_TIMEOUT_EN defined: counter runs in WB; reaching TIMEOUT_CYCLES
//   without wb_ack_i drops cyc/stb; read returns tx_data = 8'hFF via TX;
//   write silently dropped; counter cleared on entering WB.
// Not defined: WB waits on wb_ack_i indefinitely; no counter logic.
//
// TESTING
// - Write: bytes 8'h85, 8'hA5 -> one cycle we=1 adr=5 dat_o=A5; no tx_stb.
// - Read: byte 8'h03, slave acks with 8'h3C -> we=0 adr=3; tx_stb, tx_data=3C.
// - Backpressure: read, tx_ready=0 for 20 clk, next cmd byte sent -> ack not
//   toggled until tx accepted; tx_data stable; second cmd then executes.
// - Slow slave: wb_ack_i after 10 clk -> cyc/stb held 10 clk, signals stable.
// - Timeout (WBM_SPI_TIMEOUT_EN, TIMEOUT_CYCLES=16): read, no ack -> cyc drops
//   after 16 clk, tx_data=FF; next command runs normally.
// - rst asserted mid write cycle -> all outputs 0 at once; fresh 0x01 read OK.

Source files
------------

// File: rtl/wbm_spi_cmd.sv
// Wishbone-side command engine for the SPI slave byte stream.
// Imports bytes over a two-phase req/ack handshake, decodes a 1- or 2-byte
// command (bit7 = write, low bits = address) and runs one classic Wishbone
// cycle per command. Read results leave over a valid/ready byte port.
// Optional: define WBM_SPI_TIMEOUT_EN to abort cycles that never see wb_ack_i.
`timescale 1ns / 1ps

module wbm_spi_cmd #(
  parameter int unsigned ADDR_WIDTH     = 7,
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  handshake_req,
  input  logic [7:0]            handshake_data,
  output logic                  handshake_ack,
  output logic                  wb_cyc_o,
  output logic                  wb_stb_o,
  output logic                  wb_we_o,
  output logic [ADDR_WIDTH-1:0] wb_adr_o,
  output logic [7:0]            wb_dat_o,
  input  logic [7:0]            wb_dat_i,
  input  logic                  wb_ack_i,
  output logic                  tx_stb,
  output logic [7:0]            tx_data,
  input  logic                  tx_ready
);

  typedef enum logic [1:0] {StIdle, StData, StWb, StTx} state_e;

  state_e state_q;
  logic   req_meta_q;
  logic   req_sync_q;
  logic   byte_pending;

`ifdef WBM_SPI_TIMEOUT_EN
  localparam int unsigned CntW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CntW-1:0] CntLast = CntW'(TIMEOUT_CYCLES - 1);
  logic [CntW-1:0] tmo_q;
`endif

  // Two-flop synchroniser for the toggle-style request from the SPI domain.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      req_meta_q <= 1'b0;
      req_sync_q <= 1'b0;
    end else begin
      req_meta_q <= handshake_req;
      req_sync_q <= req_meta_q;
    end
  end

  // A byte is waiting whenever the synchronised request is ahead of our ack.
  assign byte_pending = req_sync_q ^ handshake_ack;

  // Command FSM; every output is a register so the bus sees clean levels.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= StIdle;
      handshake_ack <= 1'b0;
      wb_cyc_o      <= 1'b0;
      wb_stb_o      <= 1'b0;
      wb_we_o       <= 1'b0;
      wb_adr_o      <= '0;
      wb_dat_o      <= 8'h00;
      tx_stb        <= 1'b0;
      tx_data       <= 8'h00;
`ifdef WBM_SPI_TIMEOUT_EN
      tmo_q         <= '0;
`endif
    end else begin
      unique case (state_q)
        StIdle: begin
          if (byte_pending) begin
            handshake_ack <= req_sync_q;
            wb_adr_o      <= handshake_data[ADDR_WIDTH-1:0];
            wb_we_o       <= handshake_data[7];
            if (handshake_data[7]) begin
              state_q <= StData;
            end else begin
              wb_cyc_o <= 1'b1;
              wb_stb_o <= 1'b1;
              state_q  <= StWb;
`ifdef WBM_SPI_TIMEOUT_EN
              tmo_q    <= '0;
`endif
            end
          end
        end
        StData: begin
          if (byte_pending) begin
            handshake_ack <= req_sync_q;
            wb_dat_o      <= handshake_data;
            wb_cyc_o      <= 1'b1;
            wb_stb_o      <= 1'b1;
            state_q       <= StWb;
`ifdef WBM_SPI_TIMEOUT_EN
            tmo_q         <= '0;
`endif
          end
        end
        StWb: begin
          if (wb_ack_i) begin
            wb_cyc_o <= 1'b0;
            wb_stb_o <= 1'b0;
            if (!wb_we_o) begin
              tx_data <= wb_dat_i;
              tx_stb  <= 1'b1;
              state_q <= StTx;
            end else begin
              state_q <= StIdle;
            end
          end
`ifdef WBM_SPI_TIMEOUT_EN
          else if (tmo_q == CntLast) begin
            // Abandon the cycle; reads still answer so the SPI master is not starved.
            wb_cyc_o <= 1'b0;
            wb_stb_o <= 1'b0;
            if (!wb_we_o) begin
              tx_data <= 8'hFF;
              tx_stb  <= 1'b1;
              state_q <= StTx;
            end else begin
              state_q <= StIdle;
            end
          end else begin
            tmo_q <= tmo_q + 1'b1;
          end
`endif
        end
        StTx: begin
          if (tx_ready) begin
            tx_stb  <= 1'b0;
            state_q <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_wbm_spi_cmd.sv
// Scoreboard bench for wbm_spi_cmd: expected bus cycles and tx bytes are
// queued as commands are sent and compared as the DUT produces them.
`timescale 1ns / 1ps

module tb_wbm_spi_cmd;

  localparam int unsigned AW = 7;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          handshake_req = 1'b0;
  logic [7:0]    handshake_data = 8'h00;
  logic          handshake_ack;
  logic          wb_cyc_o;
  logic          wb_stb_o;
  logic          wb_we_o;
  logic [AW-1:0] wb_adr_o;
  logic [7:0]    wb_dat_o;
  logic [7:0]    wb_dat_i = 8'h00;
  logic          wb_ack_i = 1'b0;
  logic          tx_stb;
  logic [7:0]    tx_data;
  logic          tx_ready = 1'b1;

  wbm_spi_cmd #(
    .ADDR_WIDTH     (AW),
    .TIMEOUT_CYCLES (16)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .handshake_req  (handshake_req),
    .handshake_data (handshake_data),
    .handshake_ack  (handshake_ack),
    .wb_cyc_o       (wb_cyc_o),
    .wb_stb_o       (wb_stb_o),
    .wb_we_o        (wb_we_o),
    .wb_adr_o       (wb_adr_o),
    .wb_dat_o       (wb_dat_o),
    .wb_dat_i       (wb_dat_i),
    .wb_ack_i       (wb_ack_i),
    .tx_stb         (tx_stb),
    .tx_data        (tx_data),
    .tx_ready       (tx_ready)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic          we;
    logic [AW-1:0] adr;
    logic [7:0]    dat;
    int            len;  // expected cycles with cyc high; -1 = do not check
  } wb_exp_t;

  wb_exp_t    wb_q[$];
  logic [7:0] tx_q[$];

  int checks   = 0;
  int failures = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Slave model and monitors, all on the falling edge.
  int            ack_delay = 0;
  int            wait_cnt  = 0;
  int            cyc_len   = 0;
  bit            no_ack    = 1'b0;
  logic [7:0]    rdata     = 8'h00;
  logic          cap_we;
  logic [AW-1:0] cap_adr;
  logic [7:0]    cap_dat;
  bit            stable;
  bit            tx_held   = 1'b0;
  logic [7:0]    tx_first;

  always @(negedge clk) begin
    wb_exp_t e;
    if (wb_ack_i) wb_ack_i = 1'b0;
    if (wb_cyc_o) begin
      if (cyc_len == 0) begin
        cap_we  = wb_we_o;
        cap_adr = wb_adr_o;
        cap_dat = wb_dat_o;
        stable  = 1'b1;
      end else if (wb_we_o !== cap_we || wb_adr_o !== cap_adr || !wb_stb_o ||
                   (cap_we && wb_dat_o !== cap_dat)) begin
        stable = 1'b0;
      end
      cyc_len++;
      if (!no_ack) begin
        if (wait_cnt >= ack_delay) begin
          wb_ack_i = 1'b1;
          wb_dat_i = rdata;
        end else begin
          wait_cnt++;
        end
      end
    end else if (cyc_len > 0) begin
      check_eq("wb_expected", wb_q.size() != 0, 1);
      if (wb_q.size() != 0) begin
        e = wb_q.pop_front();
        check_eq("wb_we", cap_we, e.we);
        check_eq("wb_adr", cap_adr, e.adr);
        if (e.we) check_eq("wb_dat", cap_dat, e.dat);
        if (e.len >= 0) check_eq("wb_len", cyc_len, e.len);
        check_eq("wb_stable", stable, 1);
      end
      cyc_len  = 0;
      wait_cnt = 0;
    end
    if (tx_stb && !tx_held) begin
      tx_held  = 1'b1;
      tx_first = tx_data;
    end
    if (tx_stb && tx_ready) begin
      check_eq("tx_stable", tx_data, tx_first);
      check_eq("tx_expected", tx_q.size() != 0, 1);
      if (tx_q.size() != 0) check_eq("tx_data", tx_data, tx_q.pop_front());
      tx_held = 1'b0;
    end
  end

  task automatic send_byte(input logic [7:0] b);
    int n = 0;
    while (handshake_ack !== handshake_req && n < 200) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (n >= 200) check_eq("send_wait", handshake_ack, handshake_req);
    handshake_data = b;
    handshake_req  = ~handshake_req;
  endtask

  task automatic wait_done();
    bit done = 1'b0;
    for (int i = 0; i < 500 && !done; i++) begin
      @(posedge clk);
      #1;
      done = wb_q.size() == 0 && tx_q.size() == 0 && !wb_cyc_o && !tx_stb &&
             handshake_ack === handshake_req;
    end
    check_eq("drain", done, 1);
  endtask

  task automatic push_wb(input logic we, input logic [AW-1:0] adr, input logic [7:0] dat,
                         input int len);
    wb_exp_t e;
    e.we  = we;
    e.adr = adr;
    e.dat = dat;
    e.len = len;
    wb_q.push_back(e);
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    check_eq("rst_cyc", wb_cyc_o, 0);
    check_eq("rst_stb", wb_stb_o, 0);
    check_eq("rst_we", wb_we_o, 0);
    check_eq("rst_adr", wb_adr_o, 0);
    check_eq("rst_dat", wb_dat_o, 0);
    check_eq("rst_tx_stb", tx_stb, 0);
    check_eq("rst_tx_data", tx_data, 0);
    check_eq("rst_ack", handshake_ack, 0);
    rst = 1'b0;

    // Write with handshake latency check on the command byte.
    push_wb(1'b1, 7'h05, 8'hA5, 1);
    send_byte(8'h85);
    repeat (2) begin
      @(posedge clk);
      #1;
    end
    check_eq("lat_2clk", handshake_ack, !handshake_req);
    @(posedge clk);
    #1;
    check_eq("lat_3clk", handshake_ack, handshake_req);
    send_byte(8'hA5);
    wait_done();

    // Plain read.
    rdata = 8'h3C;
    push_wb(1'b0, 7'h03, 8'h00, 1);
    tx_q.push_back(8'h3C);
    send_byte(8'h03);
    wait_done();

    // Transmit backpressure holds off the next command byte.
    tx_ready = 1'b0;
    rdata    = 8'h66;
    push_wb(1'b0, 7'h04, 8'h00, 1);
    tx_q.push_back(8'h66);
    send_byte(8'h04);
    repeat (10) @(posedge clk);
    #1;
    check_eq("bp_tx_stb", tx_stb, 1);
    rdata = 8'h99;
    push_wb(1'b0, 7'h07, 8'h00, 1);
    tx_q.push_back(8'h99);
    send_byte(8'h07);
    repeat (20) @(posedge clk);
    #1;
    check_eq("bp_ack_held", handshake_ack, !handshake_req);
    check_eq("bp_tx_data", tx_data, 8'h66);
    check_eq("bp_no_cyc", wb_cyc_o, 0);
    tx_ready = 1'b1;
    wait_done();

    // Slow slave: ten cycles with cyc high.
    ack_delay = 9;
    push_wb(1'b1, 7'h0A, 8'h11, 10);
    send_byte(8'h8A);
    send_byte(8'h11);
    wait_done();
    ack_delay = 0;

`ifdef WBM_SPI_TIMEOUT_EN
    // Read nobody answers: aborted after 16 cycles, returns FF.
    no_ack = 1'b1;
    push_wb(1'b0, 7'h02, 8'h00, 16);
    tx_q.push_back(8'hFF);
    send_byte(8'h02);
    wait_done();
    no_ack = 1'b0;
    rdata  = 8'h5C;
    push_wb(1'b0, 7'h55, 8'h00, 1);
    tx_q.push_back(8'h5C);
    send_byte(8'h55);
    wait_done();
`endif

    // Reset in the middle of a write cycle.
    no_ack = 1'b1;
    push_wb(1'b1, 7'h10, 8'h5A, -1);
    send_byte(8'h90);
    send_byte(8'h5A);
    repeat (6) @(posedge clk);
    #1;
    check_eq("mid_cyc", wb_cyc_o, 1);
    #2;
    rst           = 1'b1;
    handshake_req = 1'b0;
    #1;
    check_eq("arst_cyc", wb_cyc_o, 0);
    check_eq("arst_stb", wb_stb_o, 0);
    check_eq("arst_we", wb_we_o, 0);
    check_eq("arst_adr", wb_adr_o, 0);
    check_eq("arst_dat", wb_dat_o, 0);
    check_eq("arst_tx_stb", tx_stb, 0);
    check_eq("arst_ack", handshake_ack, 0);
    @(posedge clk);
    #1;
    rst    = 1'b0;
    no_ack = 1'b0;
    rdata  = 8'hA7;
    push_wb(1'b0, 7'h01, 8'h00, 1);
    tx_q.push_back(8'hA7);
    send_byte(8'h01);
    wait_done();

    check_eq("wb_q_empty", wb_q.size(), 0);
    check_eq("tx_q_empty", tx_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
